// File: rtl/interface0_if.sv
`timescale 1ns/1ps
// Z80 bus and Pi serial link bundle; the two bidirectional lines are resolved here
// from per-side drive/enable pairs so each side only ever drives its own half.
interface interface0_if;
  logic        ZX_CLK, ZX_M1, ZX_MREQ, ZX_IORQ, ZX_RD, ZX_WR;
  logic [15:0] ZX_ADDR;
  wire  [7:0]  ZX_DATA;
  logic        ZX_NMI, ZX_RESET, ZX_WAIT, ZX_ROMCS;
  logic        PI_IO_CLK, PI_MOSI, PI_MISO;
  wire         PI_IO;
  logic [7:0]  zx_data_drv;
  logic        zx_data_oe;
  logic        pi_io_drv, pi_io_oe;
  logic        pi_io_host, pi_io_host_oe;

  assign ZX_DATA = zx_data_oe ? zx_data_drv : 8'bz;
  assign PI_IO   = pi_io_oe ? pi_io_drv : 1'bz;
  assign PI_IO   = pi_io_host_oe ? pi_io_host : 1'bz;

  modport slave (
    input  ZX_CLK, ZX_M1, ZX_MREQ, ZX_IORQ, ZX_RD, ZX_WR, ZX_ADDR,
    input  PI_IO_CLK, PI_MOSI, PI_IO,
    output ZX_NMI, ZX_RESET, ZX_WAIT, ZX_ROMCS, PI_MISO,
    output zx_data_drv, zx_data_oe, pi_io_drv, pi_io_oe
  );

  modport master (
    output ZX_CLK, ZX_M1, ZX_MREQ, ZX_IORQ, ZX_RD, ZX_WR, ZX_ADDR,
    output PI_IO_CLK, PI_MOSI, pi_io_host, pi_io_host_oe,
    input  ZX_NMI, ZX_RESET, ZX_WAIT, ZX_ROMCS, PI_MISO, ZX_DATA, PI_IO
  );
endinterface

// File: rtl/interface0.sv
`timescale 1ns/1ps
// Spectrum ROM paging bridge: Z80 reads below 0x4000 are stalled, their address is
// shifted out to the Pi, and the byte the Pi sends back is driven onto the Z80 bus.
module interface0 #(
  parameter int PULSE_LEN = 64
) (
  input logic         PI_MASTER_CLK,
  input logic         PI_RESET,
  interface0_if.slave bus
);
  localparam int CNT_W = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] PULSE_CNT = CNT_W'(PULSE_LEN);
  // {io_clk, io, mosi, mreq, rd, wr, addr}; idle levels keep reset from faking edges
  localparam logic [21:0] SYNC_IDLE = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000};

  typedef enum logic [1:0] {IDLE, SEND_ADDR, WAIT_DATA, DRIVE} state_t;
  state_t state, state_nxt;

  logic [21:0]      sync_p0, sync_p1;
  logic [1:0]       edge_p2;
  logic             io_clk_s, io_s, mosi_s, mreq_s, rd_s, wr_s;
  logic [15:0]      addr_s;
  logic             io_clk_rise, mosi_rise, mosi_fall;
  logic [4:0]       bit_cnt, addr_cnt;
  logic             frame_vld, cmd_vld, data_vld, abort, start, present;
  logic [7:0]       frame_sh, data_byte;
  logic [15:0]      addr_sh;
  logic             pi_bit, romcs;
  logic [CNT_W-1:0] reset_cnt, nmi_cnt;

  wire unused_zx = &{1'b0, bus.ZX_CLK, bus.ZX_M1, bus.ZX_IORQ};

  // stage p0/p1: two-flop synchroniser, p2: previous value for edge detection
  always_ff @(posedge PI_MASTER_CLK or posedge PI_RESET) begin
    if (PI_RESET) begin
      sync_p0 <= SYNC_IDLE;
      sync_p1 <= SYNC_IDLE;
      edge_p2 <= 2'b11;
    end else begin
      sync_p0 <= {bus.PI_IO_CLK, bus.PI_IO, bus.PI_MOSI, bus.ZX_MREQ, bus.ZX_RD,
                  bus.ZX_WR, bus.ZX_ADDR};
      sync_p1 <= sync_p0;
      edge_p2 <= {io_clk_s, mosi_s};
    end
  end

  assign {io_clk_s, io_s, mosi_s, mreq_s, rd_s, wr_s, addr_s} = sync_p1;
  assign io_clk_rise = io_clk_s & ~edge_p2[1];
  assign mosi_rise   = mosi_s & ~edge_p2[0];
  assign mosi_fall   = ~mosi_s & edge_p2[0];

  // frame_vld only rises on a MOSI edge seen after reset, so a frame cut by reset is dropped
  assign cmd_vld  = mosi_fall & frame_vld & (bit_cnt == 5'd4);
  assign data_vld = mosi_fall & frame_vld & (bit_cnt == 5'd8);
  assign abort    = ~romcs | (reset_cnt != '0) | (cmd_vld & (~frame_sh[3] | frame_sh[2]));
  assign present  = (state == SEND_ADDR) & io_clk_rise & ~mosi_s & (addr_cnt != 5'd16);
  assign start    = (state == IDLE) & (state_nxt == SEND_ADDR);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!abort && !mreq_s && !rd_s && wr_s && addr_s[15:14] == 2'b00)
                   state_nxt = SEND_ADDR;
      SEND_ADDR: if (abort) state_nxt = IDLE;
                 else if (addr_cnt == 5'd16) state_nxt = WAIT_DATA;
      WAIT_DATA: if (abort) state_nxt = IDLE;
                 else if (data_vld) state_nxt = DRIVE;
      DRIVE:     if (abort || rd_s || mreq_s) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PI_MASTER_CLK or posedge PI_RESET) begin
    if (PI_RESET) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      frame_vld <= 1'b0;
      addr_cnt  <= '0;
      romcs     <= 1'b0;
      reset_cnt <= '0;
      nmi_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (mosi_rise) begin
        bit_cnt   <= '0;
        frame_vld <= 1'b1;
      end else if (mosi_s && io_clk_rise && bit_cnt != 5'd31) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (mosi_fall) frame_vld <= 1'b0;
      if (start) addr_cnt <= '0;
      else if (present) addr_cnt <= addr_cnt + 5'd1;
      if (cmd_vld) romcs <= frame_sh[3];
      if (cmd_vld && frame_sh[2]) reset_cnt <= PULSE_CNT;
      else if (reset_cnt != '0) reset_cnt <= reset_cnt - 1'b1;
      if (cmd_vld && frame_sh[1]) nmi_cnt <= PULSE_CNT;
      else if (nmi_cnt != '0) nmi_cnt <= nmi_cnt - 1'b1;
    end
  end

  always_ff @(posedge PI_MASTER_CLK) begin
    if (mosi_s && io_clk_rise) frame_sh <= {frame_sh[6:0], io_s};
    if (start) begin
      addr_sh <= addr_s;
    end else if (present) begin
      pi_bit  <= addr_sh[15];
      addr_sh <= {addr_sh[14:0], 1'b0};
    end
    if (data_vld) data_byte <= frame_sh;
  end

  // bus releases follow the raw strobes so the DUT never fights the Pi or the Z80
  assign bus.ZX_ROMCS    = romcs;
  assign bus.ZX_RESET    = (reset_cnt == '0);
  assign bus.ZX_NMI      = (nmi_cnt == '0);
  assign bus.ZX_WAIT     = ~((state == SEND_ADDR) | (state == WAIT_DATA));
  assign bus.PI_MISO     = (state == SEND_ADDR);
  assign bus.pi_io_drv   = pi_bit;
  assign bus.pi_io_oe    = (state == SEND_ADDR) & ~bus.PI_MOSI;
  assign bus.zx_data_drv = data_byte;
  assign bus.zx_data_oe  = (state == DRIVE) & ~bus.ZX_RD;
endmodule

// File: tb/tb_interface0.sv
`timescale 1ns/1ps
// Randomised bench for interface0 against a small model of ROMCS state and the
// read-forwarding rules, plus directed reset, pulse and boundary cases.
module tb_interface0;
  localparam int PULSE_LEN = 64;

  logic clk, rst;
  int   n_chk = 0;
  int   n_fail = 0;
  logic ref_romcs;

  interface0_if bus ();
  interface0 #(.PULSE_LEN(PULSE_LEN)) dut (.PI_MASTER_CLK(clk), .PI_RESET(rst), .bus(bus));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial begin bus.ZX_CLK = 1'b0; forever #7 bus.ZX_CLK = ~bus.ZX_CLK; end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic frame_open();
    @(negedge clk);
    bus.PI_MOSI = 1'b1;
    bus.pi_io_host_oe = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_shift(input logic b);
    bus.pi_io_host = b;
    repeat (3) @(negedge clk);
    bus.PI_IO_CLK = 1'b1;
    repeat (3) @(negedge clk);
    bus.PI_IO_CLK = 1'b0;
  endtask

  task automatic frame_close();
    repeat (3) @(negedge clk);
    bus.PI_MOSI = 1'b0;
    bus.pi_io_host_oe = 1'b0;
  endtask

  task automatic frame_bits(input logic [15:0] bits, input int n);
    frame_open();
    for (int i = n - 1; i >= 0; i--) frame_shift(bits[i]);
    frame_close();
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n);
    frame_bits(bits, n);
    repeat (4) @(negedge clk);
  endtask

  task automatic pi_read_addr(output logic [15:0] a);
    a = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.PI_IO_CLK = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      a = {a[14:0], bus.PI_IO};
      @(negedge clk);
      bus.PI_IO_CLK = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic z80_read(input logic [15:0] a, input logic [7:0] d);
    logic        go;
    logic [15:0] got;
    go = ref_romcs && (a < 16'h4000);
    @(negedge clk);
    bus.ZX_ADDR = a;
    bus.ZX_MREQ = 1'b0;
    bus.ZX_RD   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rd_wait", bus.ZX_WAIT, !go);
    check_val("rd_miso", bus.PI_MISO, go);
    if (go) begin
      pi_read_addr(got);
      check_val("rd_addr", got, a);
      repeat (2) @(negedge clk);
      check_val("rd_miso_done", bus.PI_MISO, 1'b0);
      check_val("rd_wait_hold", bus.ZX_WAIT, 1'b0);
      send_frame({8'h00, d}, 8);
      check_val("rd_drive_oe", bus.zx_data_oe, 1'b1);
      check_val("rd_data", bus.ZX_DATA, d);
      check_val("rd_wait_rel", bus.ZX_WAIT, 1'b1);
    end else begin
      repeat (8) @(negedge clk);
      check_val("nogo_wait", bus.ZX_WAIT, 1'b1);
      check_val("nogo_miso", bus.PI_MISO, 1'b0);
      check_val("nogo_oe", bus.zx_data_oe, 1'b0);
    end
    @(negedge clk);
    bus.ZX_MREQ = 1'b1;
    bus.ZX_RD   = 1'b1;
    #1;
    check_val("rd_end_oe", bus.zx_data_oe, 1'b0);
    repeat (4) @(negedge clk);
    check_val("rd_end_wait", bus.ZX_WAIT, 1'b1);
    check_val("rd_end_miso", bus.PI_MISO, 1'b0);
  endtask

  initial begin
    logic [15:0] a, got;
    logic [7:0]  d;
    logic [3:0]  c;
    int          low_cnt, nmi_lo, op, n;

    rst = 1'b1;
    bus.ZX_M1 = 1'b1; bus.ZX_MREQ = 1'b1; bus.ZX_IORQ = 1'b1;
    bus.ZX_RD = 1'b1; bus.ZX_WR = 1'b1; bus.ZX_ADDR = 16'h0000;
    bus.PI_IO_CLK = 1'b0; bus.PI_MOSI = 1'b0;
    bus.pi_io_host = 1'b0; bus.pi_io_host_oe = 1'b0;
    ref_romcs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_romcs", bus.ZX_ROMCS, 1'b0);
    check_val("rst_reset", bus.ZX_RESET, 1'b1);
    check_val("rst_nmi", bus.ZX_NMI, 1'b1);
    check_val("rst_wait", bus.ZX_WAIT, 1'b1);
    check_val("rst_miso", bus.PI_MISO, 1'b0);
    check_val("rst_pi_oe", bus.pi_io_oe, 1'b0);
    check_val("rst_data_oe", bus.zx_data_oe, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // RESET_CMD with ROMCS: exact pulse width, NMI untouched
    frame_bits(16'b1100, 4);
    low_cnt = 0;
    nmi_lo  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.ZX_RESET) low_cnt++;
      if (!bus.ZX_NMI) nmi_lo++;
    end
    ref_romcs = 1'b1;
    check_val("cmd_romcs", bus.ZX_ROMCS, 1'b1);
    check_val("reset_pulse_len", low_cnt, PULSE_LEN);
    check_val("reset_released", bus.ZX_RESET, 1'b1);
    check_val("nmi_quiet", nmi_lo, 0);

    z80_read(16'h1234, 8'hCD);
    z80_read(16'h4000, 8'h11);

    send_frame(16'b0000, 4);
    ref_romcs = 1'b0;
    check_val("romcs_off", bus.ZX_ROMCS, 1'b0);
    z80_read(16'h0000, 8'h22);

    send_frame(16'h00AA, 8);
    check_val("junk8_oe", bus.zx_data_oe, 1'b0);
    check_val("junk8_romcs", bus.ZX_ROMCS, ref_romcs);
    send_frame(16'b100, 3);
    check_val("short3_romcs", bus.ZX_ROMCS, ref_romcs);
    check_val("short3_wait", bus.ZX_WAIT, 1'b1);

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          c = 4'($urandom);
          send_frame({12'h000, c}, 4);
          ref_romcs = c[3];
          check_val("rnd_cmd_romcs", bus.ZX_ROMCS, ref_romcs);
          check_val("rnd_cmd_nmi", bus.ZX_NMI, !c[1]);
          check_val("rnd_cmd_reset", bus.ZX_RESET, !c[2]);
          repeat (PULSE_LEN + 2) @(negedge clk);
          check_val("rnd_pulse_end", {bus.ZX_NMI, bus.ZX_RESET}, 2'b11);
        end
        1, 2: begin
          if ($urandom_range(0, 3) != 0) a = 16'($urandom_range(0, 16'h3FFF));
          else a = 16'($urandom_range(16'h4000, 16'hFFFF));
          d = 8'($urandom);
          z80_read(a, d);
        end
        3: begin
          send_frame(16'($urandom), 8);
          check_val("rnd_junk8_oe", bus.zx_data_oe, 1'b0);
          check_val("rnd_junk8_wait", bus.ZX_WAIT, 1'b1);
        end
        4: begin
          n = $urandom_range(1, 11);
          if (n == 4 || n == 8) n = 3;
          send_frame(16'($urandom), n);
          check_val("rnd_badlen_romcs", bus.ZX_ROMCS, ref_romcs);
        end
        default: begin
          @(negedge clk);
          bus.ZX_ADDR = 16'($urandom_range(0, 16'h3FFF));
          bus.ZX_MREQ = 1'b0;
          bus.ZX_WR   = 1'b0;
          repeat (8) @(negedge clk);
          check_val("rnd_write_wait", bus.ZX_WAIT, 1'b1);
          check_val("rnd_write_miso", bus.PI_MISO, 1'b0);
          bus.ZX_MREQ = 1'b1;
          bus.ZX_WR   = 1'b1;
          repeat (4) @(negedge clk);
        end
      endcase
    end

    // hardware reset while parked in WAIT_DATA
    send_frame(16'b1000, 4);
    ref_romcs = 1'b1;
    @(negedge clk);
    bus.ZX_ADDR = 16'h0000;
    bus.ZX_MREQ = 1'b0;
    bus.ZX_RD   = 1'b0;
    repeat (3) @(posedge clk);
    pi_read_addr(got);
    repeat (2) @(negedge clk);
    check_val("wd_wait_before", bus.ZX_WAIT, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_val("wd_rst_wait", bus.ZX_WAIT, 1'b1);
    check_val("wd_rst_miso", bus.PI_MISO, 1'b0);
    check_val("wd_rst_romcs", bus.ZX_ROMCS, 1'b0);
    @(negedge clk);
    bus.ZX_MREQ = 1'b1;
    bus.ZX_RD   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_romcs = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(16'b1000, 4);
    ref_romcs = 1'b1;
    z80_read(16'h0000, 8'h5A);

    // reset mid-frame: the tail must not decode as a command
    send_frame(16'b0000, 4);
    ref_romcs = 1'b0;
    frame_open();
    frame_shift(1'b1);
    frame_shift(1'b1);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame_shift(1'b1);
    frame_shift(1'b0);
    frame_shift(1'b0);
    frame_shift(1'b0);
    frame_close();
    repeat (4) @(negedge clk);
    check_val("midframe_romcs", bus.ZX_ROMCS, 1'b0);
    send_frame(16'b1000, 4);
    check_val("after_rst_frame", bus.ZX_ROMCS, 1'b1);

    // reset while both pulses are active
    send_frame(16'b1110, 4);
    check_val("pulses_active", {bus.ZX_NMI, bus.ZX_RESET}, 2'b00);
    #2 rst = 1'b1;
    #1;
    check_val("rst_all", {bus.ZX_ROMCS, bus.ZX_RESET, bus.ZX_NMI, bus.ZX_WAIT,
                          bus.PI_MISO, bus.pi_io_oe, bus.zx_data_oe}, 7'b0111000);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
